// File: rtl/edfic_pkg.sv
// rtl/edfic_pkg.sv - shared types, widths and deadline compare for the EDF core interface
package edfic_pkg;

    localparam int NR_IRQS  = 4;
    localparam int TS_WIDTH = 24;
    localparam int TS_CLIP  = 0;
    localparam int ID_WIDTH = $clog2(NR_IRQS);
    localparam int DL_WIDTH = TS_WIDTH + TS_CLIP;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OFFER  = 2'd1,
        SETTLE = 2'd2
    } state_e;

    typedef struct packed {
        logic [ID_WIDTH-1:0] id;
        logic [DL_WIDTH-1:0] abs_dl;
    } nest_entry_t;

    // Wrap-aware ordering: a is earlier than b when (a - b) is negative as a signed value.
    function automatic logic dl_earlier(input logic [DL_WIDTH-1:0] a,
                                        input logic [DL_WIDTH-1:0] b);
        logic [DL_WIDTH-1:0] w_diff;
        w_diff = a - b;
        return w_diff[DL_WIDTH-1];
    endfunction

endpackage

// File: rtl/edfic_core_if_if.sv
// rtl/edfic_core_if_if.sv - arbitration, core handshake and nesting status bundle
interface edfic_core_if_if #(
    parameter int NestDepth = 4
);
    import edfic_pkg::*;

    localparam int DepthWidth = $clog2(NestDepth + 1);

    logic [63:0]           mtime_i;
    logic                  arb_valid_i;
    logic [ID_WIDTH-1:0]   arb_id_i;
    logic [DL_WIDTH-1:0]   arb_dl_i;
    logic                  ack_o;
    logic [ID_WIDTH-1:0]   ack_id_o;
    logic                  core_irq_o;
    logic [ID_WIDTH-1:0]   core_id_o;
    logic                  core_ack_i;
    logic                  core_done_i;
    logic                  thr_valid_o;
    logic [DL_WIDTH-1:0]   thr_dl_o;
    logic [DepthWidth-1:0] depth_o;
    logic                  spurious_o;

    modport master (
        input  mtime_i, arb_valid_i, arb_id_i, arb_dl_i, core_ack_i, core_done_i,
        output ack_o, ack_id_o, core_irq_o, core_id_o, thr_valid_o, thr_dl_o,
               depth_o, spurious_o
    );

    modport slave (
        output mtime_i, arb_valid_i, arb_id_i, arb_dl_i, core_ack_i, core_done_i,
        input  ack_o, ack_id_o, core_irq_o, core_id_o, thr_valid_o, thr_dl_o,
               depth_o, spurious_o
    );

endinterface

// File: rtl/edfic_nest_stack.sv
// rtl/edfic_nest_stack.sv - LIFO of in-service interrupts, top entry holds the current threshold
module edfic_nest_stack
    import edfic_pkg::*;
#(
    parameter int NestDepth  = 4,
    parameter int DepthWidth = $clog2(NestDepth + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_push,
    input  logic                  i_pop,
    input  nest_entry_t           i_data,
    output nest_entry_t           o_top,
    output logic [DepthWidth-1:0] o_depth,
    output logic                  o_full,
    output logic                  o_empty
);

    nest_entry_t           r_mem [NestDepth];
    logic [DepthWidth-1:0] r_depth;

    // Storage and depth update; pop wins over push (both never arrive together).
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_depth <= '0;
            for (int i = 0; i < NestDepth; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_pop && (r_depth != '0)) begin
            r_depth <= r_depth - DepthWidth'(1);
        end else if (i_push && (r_depth != DepthWidth'(NestDepth))) begin
            for (int i = 0; i < NestDepth; i++) begin
                if (i == int'(r_depth)) begin
                    r_mem[i] <= i_data;
                end
            end
            r_depth <= r_depth + DepthWidth'(1);
        end
    end

    // Top-of-stack read, zero when empty so the threshold output idles at 0.
    always_comb begin
        o_top = '0;
        for (int i = 0; i < NestDepth; i++) begin
            if ((i + 1) == int'(r_depth)) begin
                o_top = r_mem[i];
            end
        end
    end

    assign o_depth = r_depth;
    assign o_full  = (r_depth == DepthWidth'(NestDepth));
    assign o_empty = (r_depth == '0);

endmodule

// File: rtl/edfic_core_if.sv
// rtl/edfic_core_if.sv - offers the EDF winner to the core and tracks nested service
module edfic_core_if
    import edfic_pkg::*;
#(
    parameter int NestDepth = 4
) (
    input  logic           clk_i,
    input  logic           rst_i,
    edfic_core_if_if.master bus
);

    localparam int DepthWidth = $clog2(NestDepth + 1);

    state_e                r_state;
    state_e                w_state_nxt;
    nest_entry_t           r_lat;
    nest_entry_t           w_lat_nxt;
    logic                  r_core_irq;
    logic                  w_core_irq_nxt;
    logic                  r_ack;
    logic                  w_ack_nxt;
    logic [ID_WIDTH-1:0]   r_ack_id;
    logic [ID_WIDTH-1:0]   w_ack_id_nxt;
    logic                  r_spurious;
    logic                  w_spurious_nxt;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_elig;
    nest_entry_t           w_cand;
    nest_entry_t           w_top;
    logic [DepthWidth-1:0] w_depth;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_unused_mtime;

    assign w_unused_mtime = ^bus.mtime_i[63:DL_WIDTH];

    assign w_cand.id     = bus.arb_id_i;
    assign w_cand.abs_dl = bus.arb_dl_i + bus.mtime_i[DL_WIDTH-1:0];

    // Equal deadlines never preempt; a full stack blocks everything.
    assign w_elig = bus.arb_valid_i && !w_full &&
                    (w_empty || dl_earlier(w_cand.abs_dl, w_top.abs_dl));

    edfic_nest_stack #(
        .NestDepth  (NestDepth),
        .DepthWidth (DepthWidth)
    ) u_stack (
        .i_clk   (clk_i),
        .i_rst   (rst_i),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (r_lat),
        .o_top   (w_top),
        .o_depth (w_depth),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // State, offer latch and registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_lat      <= '0;
            r_core_irq <= 1'b0;
            r_ack      <= 1'b0;
            r_ack_id   <= '0;
            r_spurious <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_lat      <= w_lat_nxt;
            r_core_irq <= w_core_irq_nxt;
            r_ack      <= w_ack_nxt;
            r_ack_id   <= w_ack_id_nxt;
            r_spurious <= w_spurious_nxt;
        end
    end

    // Next state, latch updates and stack control; done always takes precedence over ack.
    always_comb begin
        w_state_nxt    = r_state;
        w_lat_nxt      = r_lat;
        w_core_irq_nxt = r_core_irq;
        w_ack_nxt      = 1'b0;
        w_ack_id_nxt   = r_ack_id;
        w_push         = 1'b0;
        w_pop          = bus.core_done_i && !w_empty;
        w_spurious_nxt = bus.core_done_i && w_empty;

        case (r_state)
            IDLE: begin
                if (w_elig) begin
                    w_state_nxt    = OFFER;
                    w_lat_nxt      = w_cand;
                    w_core_irq_nxt = 1'b1;
                end
            end
            OFFER: begin
                if (bus.core_done_i) begin
                    w_state_nxt = OFFER;
                end else if (bus.core_ack_i) begin
                    w_push         = 1'b1;
                    w_ack_nxt      = 1'b1;
                    w_ack_id_nxt   = r_lat.id;
                    w_core_irq_nxt = 1'b0;
                    w_state_nxt    = SETTLE;
                end else if (w_elig) begin
                    w_lat_nxt = w_cand;
                end else begin
                    w_core_irq_nxt = 1'b0;
                    w_state_nxt    = IDLE;
                end
            end
            SETTLE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt    = IDLE;
                w_core_irq_nxt = 1'b0;
            end
        endcase
    end

    assign bus.ack_o       = r_ack;
    assign bus.ack_id_o    = r_ack_id;
    assign bus.core_irq_o  = r_core_irq;
    assign bus.core_id_o   = r_lat.id;
    assign bus.thr_valid_o = !w_empty;
    assign bus.thr_dl_o    = w_top.abs_dl;
    assign bus.depth_o     = w_depth;
    assign bus.spurious_o  = r_spurious;

endmodule
